// File: rtl/max_frame_pkg.sv
// Shared types and the round-robin grant search for the frame-maximum arbiter.
package max_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // First asserted bit of valid at or above ptr, wrapping within n_req requesters.
  function automatic logic [2:0] rr_next_grant(input logic [7:0]  valid,
                                               input logic [2:0]  ptr,
                                               input int unsigned n_req);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = 3'((32'(ptr) + k) % n_req);
      if (k < n_req && !found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/max_frame_arbiter_if.sv
// Requester beat streams and result channel of the frame-maximum arbiter.
interface max_frame_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4,
    parameter int SRC_W  = 1
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    res_valid;
    logic [DATA_W-1:0]       res_data;
    logic [IDX_W-1:0]        res_idx;
    logic [SRC_W-1:0]        res_src;
    logic                    res_trunc;
    logic                    res_ready;

    // Requesters and result consumer.
    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_data, res_idx, res_src, res_trunc
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_data, res_idx, res_src, res_trunc
    );
endinterface

// File: rtl/max_cmp.sv
// Unsigned greater-than comparator shared by all requesters.
module max_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);
    assign gt = (a > b);
endmodule

// File: rtl/max_frame_arbiter.sv
// Round-robin, frame-granular arbiter in front of a single max comparator;
// returns each frame's maximum, its beat index and the source requester.
module max_frame_arbiter
    import max_frame_pkg::*;
#(
    parameter int  N_REQ   = 2,
    parameter int  DATA_W  = 8,
    parameter int  MAX_LEN = 16,
    localparam int IDX_W   = $clog2(MAX_LEN),
    localparam int SRC_W   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    max_frame_arbiter_if.slave  bus
);
    state_e            state_q, state_d;
    logic [SRC_W-1:0]  grant_q, rr_ptr_q, grant_next;
    logic [IDX_W-1:0]  cnt_q, idx_q;
    logic [DATA_W-1:0] max_q, beat_data;
    logic              trunc_q, beat_valid, beat_last, accept, gt, at_limit;
    logic [7:0]        valid_ext;

    assign beat_data  = bus.req_data[int'(grant_q)*DATA_W +: DATA_W];
    assign beat_valid = bus.req_valid[grant_q];
    assign beat_last  = bus.req_last[grant_q];
    assign accept     = (state_q == RUN) && beat_valid;
    assign at_limit   = (cnt_q == IDX_W'(MAX_LEN - 1));

    max_cmp #(.W(DATA_W)) u_cmp (
        .a  (beat_data),
        .b  (max_q),
        .gt (gt)
    );

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = bus.req_valid;
    end
    assign grant_next = SRC_W'(rr_next_grant(valid_ext, 3'(rr_ptr_q), N_REQ));

    // NOTE: every output of this block gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        bus.res_valid = 1'b0;
        case (state_q)
            IDLE: if (|bus.req_valid) state_d = RUN;
            RUN: begin
                bus.req_ready[grant_q] = 1'b1;
                if (accept && (beat_last || at_limit)) state_d = OUT;
            end
            OUT: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            max_q    <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |bus.req_valid) begin
                grant_q <= grant_next;
                cnt_q   <= '0;
            end
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                // First beat loads unconditionally; later beats only on a strict win.
                if (cnt_q == '0 || gt) begin
                    max_q <= beat_data;
                    idx_q <= cnt_q;
                end
                if (beat_last)     trunc_q <= 1'b0;
                else if (at_limit) trunc_q <= 1'b1;
            end
            if (state_q == OUT && bus.res_ready)
                rr_ptr_q <= (grant_q == SRC_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    assign bus.res_data  = max_q;
    assign bus.res_idx   = idx_q;
    assign bus.res_src   = grant_q;
    assign bus.res_trunc = trunc_q;

endmodule

// File: tb/tb_max_frame_arbiter.sv
// Directed-vector bench for max_frame_arbiter with two requesters, 8-bit data, 16-beat frames.
module tb_max_frame_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v0 = 0, v1 = 0, l0 = 0, l1 = 0, res_rdy = 1;
    logic [7:0] d0 = 0, d1 = 0;
    logic mon_excl = 0;
    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    max_frame_arbiter_if #(.N_REQ(2), .DATA_W(8), .IDX_W(4), .SRC_W(1)) bus ();

    assign bus.req_valid = {v1, v0};
    assign bus.req_data  = {d1, d0};
    assign bus.req_last  = {l1, l0};
    assign bus.res_ready = res_rdy;

    max_frame_arbiter #(.N_REQ(2), .DATA_W(8), .MAX_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (mon_excl) check("ready_excl", 32'(bus.req_ready == 2'b11), 0);

    task automatic drive(input bit r, input logic v, input logic [7:0] d, input logic l);
        if (r) begin v1 = v; d1 = d; l1 = l; end
        else   begin v0 = v; d0 = d; l0 = l; end
    endtask

    // Presents one beat and returns just after the edge that accepted it.
    task automatic beat(input bit r, input logic [7:0] d, input logic l);
        int t = 0;
        drive(r, 1'b1, d, l);
        while (1) begin
            @(negedge clk);
            if (bus.req_ready[r]) break;
            t++;
            if (t >= 300) begin
                check("beat_timeout", 0, 1);
                drive(r, 1'b0, 8'd0, 1'b0);
                return;
            end
        end
        @(posedge clk); #1;
        drive(r, 1'b0, d, 1'b0);
    endtask

    task automatic expect_res(input string tag, input logic [7:0] d, input logic [3:0] i,
                              input logic s, input logic tr);
        int t = 0;
        while (1) begin
            @(negedge clk);
            if (bus.res_valid) break;
            t++;
            if (t >= 300) begin
                check({tag, ".timeout"}, 0, 1);
                return;
            end
        end
        check({tag, ".data"},  32'(bus.res_data),  32'(d));
        check({tag, ".idx"},   32'(bus.res_idx),   32'(i));
        check({tag, ".src"},   32'(bus.res_src),   32'(s));
        check({tag, ".trunc"}, 32'(bus.res_trunc), 32'(tr));
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst.req_ready", 32'(bus.req_ready), 0);
        check("rst.res_valid", 32'(bus.res_valid), 0);
        check("rst.res_data",  32'(bus.res_data),  0);
        check("rst.res_idx",   32'(bus.res_idx),   0);
        check("rst.res_src",   32'(bus.res_src),   0);
        check("rst.res_trunc", 32'(bus.res_trunc), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Both requesters busy: grants alternate 0,1,0,1
        mon_excl = 1'b1;
        fork
            begin beat(0, 8'd5, 0); beat(0, 8'd7, 1); beat(0, 8'd8, 0); beat(0, 8'd8, 1); end
            begin beat(1, 8'd4, 0); beat(1, 8'd2, 1); beat(1, 8'd1, 0); beat(1, 8'd6, 1); end
            begin
                expect_res("rr0", 8'd7, 4'd1, 1'b0, 1'b0);
                expect_res("rr1", 8'd4, 4'd0, 1'b1, 1'b0);
                expect_res("rr2", 8'd8, 4'd0, 1'b0, 1'b0);
                expect_res("rr3", 8'd6, 4'd1, 1'b1, 1'b0);
            end
        join
        mon_excl = 1'b0;

        // Frame 3,9,2,9: tie keeps earliest index
        fork
            begin beat(0, 8'd3, 0); beat(0, 8'd9, 0); beat(0, 8'd2, 0); beat(0, 8'd9, 1); end
            expect_res("f3929", 8'd9, 4'd1, 1'b0, 1'b0);
        join

        // 17 beats 0..16 from requester 1: cut at 16, remainder is its own frame
        fork
            for (int k = 0; k < 17; k++) beat(1, 8'(k), (k == 16));
            begin
                expect_res("trunc", 8'd15, 4'd15, 1'b1, 1'b1);
                expect_res("tail",  8'd16, 4'd0,  1'b1, 1'b0);
            end
        join

        // Result back-pressure: outputs held, no beats accepted
        res_rdy = 1'b0;
        beat(0, 8'd10, 0); beat(0, 8'd30, 0); beat(0, 8'd20, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold.res_valid", 32'(bus.res_valid), 1);
            check("hold.res_data",  32'(bus.res_data),  30);
            check("hold.res_idx",   32'(bus.res_idx),   1);
            check("hold.res_src",   32'(bus.res_src),   0);
            check("hold.res_trunc", 32'(bus.res_trunc), 0);
            check("hold.req_ready", 32'(bus.req_ready), 0);
        end
        res_rdy = 1'b1;
        @(posedge clk); #1;
        check("release.res_valid", 32'(bus.res_valid), 0);

        // Reset mid-frame after 2 of 4 beats
        beat(0, 8'd50, 0); beat(0, 8'd60, 0);
        drive(0, 1'b1, 8'd70, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst.req_ready", 32'(bus.req_ready), 0);
        check("arst.res_valid", 32'(bus.res_valid), 0);
        check("arst.res_data",  32'(bus.res_data),  0);
        check("arst.res_idx",   32'(bus.res_idx),   0);
        check("arst.res_src",   32'(bus.res_src),   0);
        drive(0, 1'b0, 8'd0, 1'b0);
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
        // Both valid after reset: rr_ptr back at 0 means requester 0 goes first
        fork
            begin beat(0, 8'd50, 0); beat(0, 8'd60, 0); beat(0, 8'd70, 0); beat(0, 8'd65, 1); end
            beat(1, 8'd3, 1);
            begin
                expect_res("restart", 8'd70, 4'd2, 1'b0, 1'b0);
                expect_res("post_rst_r1", 8'd3, 4'd0, 1'b1, 1'b0);
            end
        join

        // Single beat 0xFF with stalls on req_valid
        drive(0, 1'b1, 8'hFF, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'hFF, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall.req_ready", 32'(bus.req_ready), 1);
            check("stall.res_valid", 32'(bus.res_valid), 0);
        end
        @(posedge clk); #1;
        fork
            beat(0, 8'hFF, 1);
            expect_res("single", 8'hFF, 4'd0, 1'b0, 1'b0);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/max_frame_arbiter.md
Name: max_frame_arbiter

Overview:
- Shares one unsigned max comparator between N_REQ requesters.
- Each requester streams a frame of words over valid/ready; the block returns the frame maximum, its index within the frame, and the source requester.
- Sits in front of the max datapath. It sequences frames one at a time and grants requesters in round-robin order at frame granularity.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, word width; compared unsigned.
- MAX_LEN, 16, maximum beats per frame (power of two, at least 2).
- IDX_W, $clog2(MAX_LEN), index/counter width (derived).
- SRC_W, $clog2(N_REQ), source id width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*DATA_W  per-requester beat data; requester i occupies slice [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  marks the final beat of a frame.
- req_ready  out  N_REQ  per-requester beat accept.
- res_valid  out  1  result valid.
- res_data  out  DATA_W  frame maximum.
- res_idx  out  IDX_W  beat index of the maximum.
- res_src  out  SRC_W  requester that supplied the frame.
- res_trunc  out  1  frame was cut at MAX_LEN beats.
- res_ready  in  1  result accept.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, rr_ptr=0, grant=0, cnt=0.
  - All outputs 0: req_ready=0, res_valid=0, res_data=0, res_idx=0, res_src=0, res_trunc=0.
  - Reset asserted mid-frame or mid-result aborts the frame; no result is produced.
- States: IDLE, RUN, OUT.
- IDLE:
  - req_ready all 0.
  - If any req_valid is high, register grant = first asserted requester searching from rr_ptr upward with wrap. Set cnt=0 and go to RUN.
  - Arbitration costs exactly 1 cycle; no beat is accepted in IDLE.
- RUN:
  - req_ready[grant]=1; every other requester sees 0.
  - A beat is accepted when req_valid[grant] and req_ready[grant] are both high.
  - First beat (cnt==0): max<=data, idx<=0.
  - Later beats: if data>max (strict, unsigned, via the comparator) then max<=data and idx<=cnt. Ties keep the earliest index.
  - cnt increments on every accepted beat.
  - If the accepted beat has req_last=1: trunc<=0, go to OUT.
  - Else if cnt==MAX_LEN-1: trunc<=1, go to OUT. The requester's remaining beats form a new frame in a later grant.
  - No accepted beat: hold all state; stalls have no limit.
- OUT:
  - res_valid=1. res_data, res_idx, res_src and res_trunc are registered and held stable until accepted.
  - On res_ready: rr_ptr<=grant+1 (wraps modulo N_REQ), go to IDLE.
  - Minimum frame-to-frame overhead is 2 cycles (OUT + IDLE).
- res_valid may not drop without res_ready.
- req_valid on non-granted requesters never affects the current frame.
- Back-to-back: a single active requester is re-granted after each frame. With requesters 0 and 1 both active, grants alternate 0,1,0,1.
- Single-beat frame: result = that beat, res_idx=0.

Decomposition:
- Package max_frame_pkg: state enum (IDLE/RUN/OUT) and a function for the round-robin next-grant search.
- One sub-module, max_cmp: purely combinational unsigned compare. Inputs a, b; output gt = (a>b). Instantiated once in the datapath.

Test Plan:
- Requester 0 sends frame 3,9,2,9 (last on beat 4) -> res_data=9, res_idx=1, res_src=0, res_trunc=0.
- Requesters 0 and 1 both hold valid with two-beat frames, repeated -> grant order 0,1,0,1. req_ready is never high on both requesters in the same cycle.
- Requester 1 sends 17 beats of values 0..16 with no last (MAX_LEN=16) -> first result res_data=15, res_idx=15, res_trunc=1. The next frame from requester 1 is the single beat 16, giving res_idx=0.
- res_ready held low for 5 cycles in OUT -> outputs stable, req_ready all 0. Release -> IDLE on the next cycle.
- rst pulsed in RUN after 2 of 4 beats -> all outputs 0 asynchronously, no result emitted, rr_ptr=0. The restarted frame is computed correctly.
- Single-beat frame 0xFF with req_valid gapped by stalls -> res_data=0xFF, res_idx=0.
